// File: rtl/uob_vlen.sv
`timescale 1ns/1ps
// uob_vlen: single-clock packet queue for variable-length, thread-tagged packets.
// The CPU fills one slot at a time; the read side emits marker/thread/len then data serialised to OUT_WIDTH.
module uob_vlen #(
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = 8,
  parameter int RATIO         = IN_WIDTH / OUT_WIDTH,
  parameter int MAX_PKT_LEN   = 64,
  parameter int ADDR_MSB      = $clog2(MAX_PKT_LEN) - 1,
  parameter int PKT_QUEUE_MSB = 2,
  parameter int N_THREADS     = 16,
  parameter int N_THREADS_MSB = (N_THREADS > 1) ? $clog2(N_THREADS) - 1 : 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_WIDTH-1:0]      din,
  input  logic                     wr_en,
  input  logic [ADDR_MSB:0]        wr_addr,
  input  logic [N_THREADS_MSB:0]   wr_thread,
  input  logic                     set_input_complete,
  input  logic                     abort,
  output logic                     ready,
  output logic                     full,
  output logic                     err,
  output logic [OUT_WIDTH-1:0]     dout,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [PKT_QUEUE_MSB:0]   pkt_count
);

  localparam int QW      = PKT_QUEUE_MSB + 1;
  localparam int SLOTS   = 1 << QW;
  localparam int AW      = ADDR_MSB + 1;
  localparam int TW      = N_THREADS_MSB + 1;
  localparam int LEN_W   = $clog2(MAX_PKT_LEN + 1);
  localparam int CNT_W   = $clog2(MAX_PKT_LEN * RATIO + 1);
  localparam int SLICE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int DEPTH   = SLOTS * MAX_PKT_LEN;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_MARK, S_HDR_THREAD, S_HDR_LEN, S_DATA, S_END
  } state_t;

  function automatic logic [OUT_WIDTH-1:0] zext_thread(input logic [TW-1:0] t);
    return OUT_WIDTH'(t);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] zext_len(input logic [LEN_W-1:0] l);
    return OUT_WIDTH'(l);
  endfunction

  // Storage: packet words plus one {thread, len} descriptor per slot
  logic [IN_WIDTH-1:0]  r_mem         [DEPTH];
  logic [TW-1:0]        r_desc_thread [SLOTS];
  logic [LEN_W-1:0]     r_desc_len    [SLOTS];

  // Write-side state
  logic [QW-1:0]        r_wr_ptr;
  logic                 r_in_prog;
  logic [LEN_W-1:0]     r_len;
  logic [TW-1:0]        r_thread;
  logic                 r_err;

  // Read-side state
  state_t               r_state;
  logic [QW-1:0]        r_rd_ptr;
  logic [QW-1:0]        r_pkt_cnt;
  logic                 r_empty;
  logic [OUT_WIDTH-1:0] r_dout;
  logic [CNT_W-1:0]     r_dcnt;
  logic [SLICE_W-1:0]   r_slice;
  logic [AW-1:0]        r_word;
  logic [IN_WIDTH-1:0]  r_rdata_p1;
  logic [IN_WIDTH-1:0]  r_shift;

  logic                 w_full;
  logic                 w_ready;
  logic                 w_wr_acc;
  logic                 w_wr_rej;
  logic                 w_commit;
  logic                 w_commit_rej;
  logic [LEN_W-1:0]     w_addr_len;
  logic [LEN_W-1:0]     w_len_next;
  logic [CNT_W-1:0]     w_total;
  logic                 w_start;
  logic                 w_emit;
  logic                 w_load;
  logic [AW-1:0]        w_rd_word;
  logic                 w_dec;
  logic [QW-1:0]        w_cnt_next;
  logic                 w_idle_next;

  assign w_full       = (r_pkt_cnt == QW'(SLOTS - 1));
  assign w_ready      = ~r_in_prog & ~w_full;
  assign w_wr_acc     = wr_en & (r_in_prog | w_ready) & ~abort;
  assign w_wr_rej     = wr_en & ~r_in_prog & ~w_ready;
  assign w_commit     = set_input_complete & r_in_prog & ~abort;
  assign w_commit_rej = set_input_complete & ~r_in_prog & ~abort;
  assign w_addr_len   = LEN_W'(wr_addr) + LEN_W'(1);
  assign w_len_next   = (w_wr_acc && (w_addr_len > r_len)) ? w_addr_len : r_len;

  assign w_total      = CNT_W'(r_desc_len[r_rd_ptr]) * CNT_W'(RATIO);
  assign w_start      = (r_state == S_IDLE) & rd_en & ~r_empty;
  assign w_emit       = (r_state == S_HDR_LEN) |
                        ((r_state == S_DATA) & (r_dcnt != w_total));
  // A new input word is unpacked whenever the slice counter wraps; prefetch the next one
  // on that same edge so RATIO=1 still streams without bubbles.
  assign w_load       = w_emit & (r_slice == '0);
  assign w_rd_word    = w_load ? r_word + AW'(1) : r_word;
  assign w_dec        = (r_state == S_END);
  assign w_cnt_next   = r_pkt_cnt + QW'(w_commit) - QW'(w_dec);
  assign w_idle_next  = (r_state == S_END) | ((r_state == S_IDLE) & ~w_start);

  assign ready     = w_ready;
  assign full      = w_full;
  assign err       = r_err;
  assign dout      = r_dout;
  assign empty     = r_empty;
  assign pkt_count = r_pkt_cnt;

  // Datapath: memory, descriptors, read pipeline (no reset)
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[{r_wr_ptr, wr_addr}] <= din;
      if (!r_in_prog) r_thread <= wr_thread;
    end
    if (w_commit) begin
      r_desc_thread[r_wr_ptr] <= r_thread;
      r_desc_len[r_wr_ptr]    <= w_len_next;
    end
    r_rdata_p1 <= r_mem[{r_rd_ptr, w_rd_word}];
    if (w_emit) r_shift <= (w_load ? r_rdata_p1 : r_shift) >> OUT_WIDTH;
  end

  // Write-side control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_in_prog <= 1'b0;
      r_len     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_wr_rej || w_commit_rej) r_err <= 1'b1;
      if (abort) begin
        r_in_prog <= 1'b0;
        r_len     <= '0;
      end else if (w_commit) begin
        r_wr_ptr  <= r_wr_ptr + QW'(1);
        r_in_prog <= 1'b0;
        r_len     <= '0;
      end else if (w_wr_acc) begin
        r_in_prog <= 1'b1;
        r_len     <= w_len_next;
      end
    end
  end

  // Read FSM: dout, empty and pkt_count are registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_dout    <= '0;
      r_empty   <= 1'b1;
      r_rd_ptr  <= '0;
      r_pkt_cnt <= '0;
      r_dcnt    <= '0;
      r_slice   <= '0;
      r_word    <= '0;
    end else begin
      r_pkt_cnt <= w_cnt_next;
      r_empty   <= ~(w_idle_next & (w_cnt_next != '0));
      r_word    <= (r_state == S_END) ? '0 : w_rd_word;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_HDR_MARK;
            r_dout  <= '1;
          end else begin
            r_dout  <= '0;
          end
        end
        S_HDR_MARK: begin
          r_state <= S_HDR_THREAD;
          r_dout  <= zext_thread(r_desc_thread[r_rd_ptr]);
        end
        S_HDR_THREAD: begin
          r_state <= S_HDR_LEN;
          r_dout  <= zext_len(r_desc_len[r_rd_ptr]);
        end
        S_HDR_LEN, S_DATA: begin
          if (w_emit) begin
            r_state <= S_DATA;
            r_dout  <= w_load ? r_rdata_p1[OUT_WIDTH-1:0] : r_shift[OUT_WIDTH-1:0];
            r_dcnt  <= r_dcnt + CNT_W'(1);
            r_slice <= (r_slice == SLICE_W'(RATIO - 1)) ? '0 : r_slice + SLICE_W'(1);
          end else begin
            r_state <= S_END;
            r_dout  <= '0;
          end
        end
        S_END: begin
          r_state  <= S_IDLE;
          r_dout   <= '0;
          r_rd_ptr <= r_rd_ptr + QW'(1);
          r_dcnt   <= '0;
          r_slice  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_dout  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uob_vlen.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for uob_vlen: a packet-level queue model predicts the
// output byte stream, a negedge monitor compares it against dout.
module tb_uob_vlen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [3:0]  wr_thread = '0;
  logic        set_input_complete = 1'b0;
  logic        abort = 1'b0;
  logic        ready, full, err, empty;
  logic [7:0]  dout;
  logic        rd_en = 1'b0;
  logic [2:0]  pkt_count;

  always #5 clk = ~clk;

  uob_vlen #(
    .IN_WIDTH(16), .OUT_WIDTH(8), .MAX_PKT_LEN(64), .PKT_QUEUE_MSB(2), .N_THREADS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_thread(wr_thread), .set_input_complete(set_input_complete), .abort(abort),
    .ready(ready), .full(full), .err(err), .dout(dout), .rd_en(rd_en),
    .empty(empty), .pkt_count(pkt_count)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: committed packets in order
  int m_thr[$];
  int m_len[$];
  int m_data[$];

  // Scoreboard: expected output bytes and per-packet byte counts
  int exp_bytes[$];
  int exp_pkt_n[$];
  bit mon_en = 1'b1;
  bit mon_busy = 1'b0;
  int mon_rem = 0;

  int ready_at_dec = 0;
  int ready_before_dec = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (!mon_busy) begin
        if (dout == 8'hFF) begin
          if (exp_pkt_n.size() == 0) chk("unexpected_marker", int'(dout), 0);
          else begin
            mon_rem  = exp_pkt_n.pop_front();
            mon_busy = 1'b1;
          end
        end else begin
          chk("idle_dout", int'(dout), 0);
        end
      end
      if (mon_busy) begin
        chk("stream_byte", int'(dout), exp_bytes.pop_front());
        mon_rem--;
        if (mon_rem == 0) mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d, input int t);
    wr_en = 1'b1;
    wr_addr = a[5:0];
    din = d[15:0];
    wr_thread = t[3:0];
    tick();
    wr_en = 1'b0;
  endtask

  task automatic commit_pkt();
    set_input_complete = 1'b1;
    tick();
    set_input_complete = 1'b0;
  endtask

  task automatic write_pkt(input int t, input int len, input bit pre_abort);
    int words[64];
    int n;
    int a;
    if (pre_abort) begin
      n = 1 + int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) write_word(i, int'($urandom_range(0, 65535)), (t + 3) % 16);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    for (int i = 0; i < len; i++) words[i] = int'($urandom_range(0, 65535));
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < len; i++)
        write_word(i, words[i], (i == 0) ? t : int'($urandom_range(0, 15)));
    end else begin
      for (int i = len - 1; i >= 0; i--)
        write_word(i, words[i], (i == len - 1) ? t : int'($urandom_range(0, 15)));
    end
    if (len > 1 && $urandom_range(0, 1) == 1) begin
      a = int'($urandom_range(0, len - 1));
      words[a] = int'($urandom_range(0, 65535));
      write_word(a, words[a], int'($urandom_range(0, 15)));
    end
    commit_pkt();
    m_thr.push_back(t);
    m_len.push_back(len);
    for (int i = 0; i < len; i++) m_data.push_back(words[i]);
    chk("pkt_count_commit", int'(pkt_count), m_len.size());
  endtask

  task automatic push_expected();
    int t, len, w;
    t = m_thr.pop_front();
    len = m_len.pop_front();
    exp_bytes.push_back(255);
    exp_bytes.push_back(t);
    exp_bytes.push_back(len);
    for (int i = 0; i < len; i++) begin
      w = m_data.pop_front();
      exp_bytes.push_back(w % 256);
      exp_bytes.push_back((w / 256) % 256);
    end
    exp_bytes.push_back(0);
    exp_pkt_n.push_back(4 + 2 * len);
  endtask

  task automatic read_pkt();
    int k, prev, len;
    bit seen;
    if (m_len.size() == 0) return;
    k = 0;
    while (empty && k < 100) begin
      tick();
      k++;
    end
    if (empty) begin
      chk("empty_wait_timeout", 1, 0);
      return;
    end
    len = m_len[0];
    push_expected();
    prev = int'(pkt_count);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    seen = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) chk("empty_after_rd", int'(empty), 1);
      if (int'(pkt_count) != prev) begin
        seen = 1'b1;
        ready_at_dec = int'(ready);
        break;
      end
      ready_before_dec = int'(ready);
    end
    chk("dec_latency", seen ? k : -1, 5 + 2 * len);
    chk("pkt_count_read", int'(pkt_count), m_len.size());
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, int'(ready), 1);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_dout"}, int'(dout), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_pkt_count"}, int'(pkt_count), 0);
  endtask

  initial begin
    int t, n;
    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("rst_rel");

    // Directed 4-word packet, thread 5
    write_word(0, 16'h1234, 5);
    chk("ready_in_prog", int'(ready), 0);
    write_word(1, 16'h5678, 5);
    write_word(2, 16'h9ABC, 5);
    write_word(3, 16'hDEF0, 5);
    commit_pkt();
    m_thr.push_back(5); m_len.push_back(4);
    m_data.push_back(16'h1234); m_data.push_back(16'h5678);
    m_data.push_back(16'h9ABC); m_data.push_back(16'hDEF0);
    chk("pkt_count_one", int'(pkt_count), 1);
    chk("empty_after_commit", int'(empty), 0);
    read_pkt();

    // Fill all 7 usable slots with one-word packets
    for (int i = 0; i < 7; i++) write_pkt(i, 1, 1'b0);
    chk("full_set", int'(full), 1);
    chk("ready_full", int'(ready), 0);
    write_word(0, 16'h5555, 9);
    chk("err_on_full_write", int'(err), 1);
    chk("pkt_count_full", int'(pkt_count), 7);
    chk("ready_still_full", int'(ready), 0);
    read_pkt();
    chk("ready_after_free", ready_at_dec, 1);
    chk("ready_before_free", ready_before_dec, 0);
    chk("full_cleared", int'(full), 0);
    while (m_len.size() > 0) read_pkt();

    // Abort then short rewrite
    write_word(0, int'($urandom_range(0, 65535)), 6);
    write_word(1, int'($urandom_range(0, 65535)), 6);
    write_word(2, int'($urandom_range(0, 65535)), 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ready_after_abort", int'(ready), 1);
    write_word(0, 16'hAAAA, 6);
    commit_pkt();
    m_thr.push_back(6); m_len.push_back(1); m_data.push_back(16'hAAAA);
    chk("pkt_count_abort", int'(pkt_count), 1);
    read_pkt();

    // Commit coinciding with the END cycle of a read
    for (int i = 0; i < 3; i++) write_pkt(10 + i, 1, 1'b0);
    n = int'($urandom_range(0, 65535));
    write_word(0, n, 13);
    push_expected();
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pkt_count_pre_end", int'(pkt_count), 3);
    set_input_complete = 1'b1;
    @(posedge clk);
    #1;
    set_input_complete = 1'b0;
    m_thr.push_back(13); m_len.push_back(1); m_data.push_back(n);
    chk("pkt_count_same_cycle", int'(pkt_count), 3);
    chk("full_same_cycle", int'(full), 0);
    tick();
    while (m_len.size() > 0) read_pkt();

    // Randomised traffic wrapping the slot ring three times
    for (int i = 0; i < 24; i++) begin
      if (m_len.size() == 7 || (m_len.size() > 0 && $urandom_range(0, 2) == 0)) read_pkt();
      t = (i == 10) ? 64 : int'($urandom_range(1, 6));
      write_pkt(i % 16, t, $urandom_range(0, 3) == 0);
    end
    while (m_len.size() > 0) read_pkt();
    repeat (3) tick();

    // Reset in the middle of DATA
    write_pkt(7, 4, 1'b0);
    mon_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid_read");
    rst_n = 1'b1;
    m_thr.delete(); m_len.delete(); m_data.delete();
    exp_bytes.delete(); exp_pkt_n.delete();
    mon_busy = 1'b0;
    mon_rem = 0;
    tick();
    mon_en = 1'b1;

    // Reset in the middle of a write
    write_word(0, 16'h1111, 2);
    write_word(1, 16'h2222, 2);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid_write");
    rst_n = 1'b1;
    tick();
    write_pkt(12, 3, 1'b0);
    read_pkt();

    // Commit with nothing in progress is rejected
    chk("err_clear", int'(err), 0);
    commit_pkt();
    chk("err_bad_commit", int'(err), 1);
    chk("pkt_count_bad_commit", int'(pkt_count), 0);

    repeat (4) tick();
    chk("sb_drained", exp_bytes.size() + int'(mon_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
